// File: rtl/alu_ctrl_pkg.sv
// Shared op codes and sequencer state encoding for the ALU control unit.
package alu_ctrl_pkg;

  // Iterations for multiply and divide; the datapath counter wraps after this many.
  localparam int unsigned N_ITER_DEF = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StLdM    = 4'd1,
    StLdQ    = 4'd2,
    StMTest  = 4'd3,
    StMShift = 4'd4,
    StDShift = 4'd5,
    StDSub   = 4'd6,
    StDChk   = 4'd7,
    StDRest  = 4'd8,
    StDFinal = 4'd9,
    StOut    = 4'd10
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of sequencer state into datapath strobes and handshake outputs.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [1:0] i_op,
  input  logic       i_a7,
  input  logic       i_qbit,
  input  logic       i_q0,
  input  logic       i_qm1,
  output logic [7:0] o_c,
  output logic       o_opnd_sel,
  output logic       o_busy,
  output logic       o_done
);

  state_e w_state;
  assign w_state = state_e'(i_state);

  // Strobe pattern per state; everything defaults low.
  always_comb begin
    o_c        = 8'h00;
    o_opnd_sel = 1'b0;
    o_busy     = (w_state != StIdle);
    o_done     = 1'b0;
    case (w_state)
      StLdM: o_c[0] = 1'b1;
      StLdQ: begin
        o_c[1]     = 1'b1;
        o_opnd_sel = 1'b1;
      end
      StMTest: begin
        // Booth pair: 10 subtracts M, 01 adds M, 00/11 leave A alone.
        if (i_q0 != i_qm1) begin
          o_c[2] = 1'b1;
          o_c[3] = i_q0;
        end
      end
      StMShift: begin
        o_c[4] = 1'b1;
        o_c[5] = 1'b1;
        o_c[6] = i_a7;
      end
      StDShift: begin
        o_c[4] = 1'b1;
        o_c[6] = i_qbit;
      end
      StDSub: begin
        o_c[2] = 1'b1;
        o_c[3] = 1'b1;
      end
      StDChk:  o_c[5] = 1'b1;
      StDRest: o_c[2] = 1'b1;
      StDFinal: begin
        o_c[4] = 1'b1;
        o_c[6] = i_qbit;
      end
      StOut: begin
        o_c[7] = 1'b1;
        o_c[3] = i_op[0];
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_control_unit.sv
// Sequencer for the 8-bit add/sub, Booth multiply and restoring divide datapath.
module alu_control_unit
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned N_ITER = N_ITER_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [1:0] i_op_in,
  input  logic       i_cnt_done,
  input  logic       i_q0,
  input  logic       i_qm1,
  input  logic       i_a7,
  output logic [1:0] o_op,
  output logic       o_c0,
  output logic       o_c1,
  output logic       o_c2,
  output logic       o_c3,
  output logic       o_c4,
  output logic       o_c5,
  output logic       o_c6,
  output logic       o_c7,
  output logic       o_opnd_sel,
  output logic       o_busy,
  output logic       o_done
);

  // The datapath counter is 3 bits and flags done at 3'b111, so only 8 iterations work.
  if (N_ITER != 8) begin : g_n_iter_check
    $error("alu_control_unit: N_ITER must be 8 to match the datapath counter");
  end

  state_e     r_state, w_state_next;
  logic [1:0] r_op, w_op_next;
  logic       r_qbit, w_qbit_next;
  logic       r_cnt_done_seen, w_cnt_done_seen_next;
  logic [7:0] w_c;

  // Next-state logic plus op latch, quotient bit and counter-wrap tracking.
  always_comb begin
    w_state_next         = r_state;
    w_op_next            = r_op;
    w_qbit_next          = r_qbit;
    w_cnt_done_seen_next = r_cnt_done_seen;
    unique case (r_state)
      StIdle: begin
        w_cnt_done_seen_next = 1'b0;
        if (i_start) begin
          w_state_next = StLdM;
          w_op_next    = i_op_in;
        end
      end
      StLdM: begin
        w_qbit_next  = 1'b0;
        w_state_next = StLdQ;
      end
      StLdQ: begin
        if (r_op[1]) begin
          w_state_next = (r_op == OP_MUL) ? StMTest : StDShift;
        end else begin
          w_state_next = StOut;
        end
      end
      StMTest:  w_state_next = StMShift;
      StMShift: w_state_next = i_cnt_done ? StOut : StMTest;
      StDShift: w_state_next = StDSub;
      StDSub:   w_state_next = StDChk;
      StDChk: begin
        w_qbit_next = ~i_a7;
        if (i_cnt_done) begin
          w_cnt_done_seen_next = 1'b1;
        end
        if (i_a7) begin
          w_state_next = StDRest;
        end else begin
          w_state_next = i_cnt_done ? StDFinal : StDShift;
        end
      end
      // Counter has already wrapped to 0 here, so rely on the flag captured in StDChk.
      StDRest:  w_state_next = r_cnt_done_seen ? StDFinal : StDShift;
      StDFinal: w_state_next = StOut;
      StOut:    w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state         <= StIdle;
      r_op            <= OP_ADD;
      r_qbit          <= 1'b0;
      r_cnt_done_seen <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_op            <= w_op_next;
      r_qbit          <= w_qbit_next;
      r_cnt_done_seen <= w_cnt_done_seen_next;
    end
  end

  alu_ctrl_decode u_decode (
    .i_state    (r_state),
    .i_op       (r_op),
    .i_a7       (i_a7),
    .i_qbit     (r_qbit),
    .i_q0       (i_q0),
    .i_qm1      (i_qm1),
    .o_c        (w_c),
    .o_opnd_sel (o_opnd_sel),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  assign o_op = r_op;
  assign o_c0 = w_c[0];
  assign o_c1 = w_c[1];
  assign o_c2 = w_c[2];
  assign o_c3 = w_c[3];
  assign o_c4 = w_c[4];
  assign o_c5 = w_c[5];
  assign o_c6 = w_c[6];
  assign o_c7 = w_c[7];

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench: control unit paired with a behavioural datapath, checked every cycle against an
// integer-arithmetic model of the expected strobe sequence and result.
module tb_alu_control_unit;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [1:0] op_in, op_o;
  logic       cnt_done, q0, qm1, a7;
  logic       c0, c1, c2, c3, c4, c5, c6, c7, opnd_sel, busy, done;
  logic [7:0] x_val, y_val;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  logic [15:0] last_z = 16'h0;

  alu_control_unit #(.N_ITER(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op_in(op_in),
    .i_cnt_done(cnt_done), .i_q0(q0), .i_qm1(qm1), .i_a7(a7),
    .o_op(op_o), .o_c0(c0), .o_c1(c1), .o_c2(c2), .o_c3(c3), .o_c4(c4), .o_c5(c5),
    .o_c6(c6), .o_c7(c7), .o_opnd_sel(opnd_sel), .o_busy(busy), .o_done(done)
  );

  logic [12:0] w_act;
  assign w_act = {op_o, done, busy, opnd_sel, c7, c6, c5, c4, c3, c2, c1, c0};

  // Behavioural datapath; A is kept 9 bits wide so its sign is exact.
  logic [8:0] dp_a;
  logic [7:0] dp_q, dp_m, bus;
  logic       dp_qm1;
  logic [2:0] dp_cnt;
  assign bus      = opnd_sel ? y_val : x_val;
  assign cnt_done = (dp_cnt == 3'd7);
  assign q0       = dp_q[0];
  assign qm1      = dp_qm1;
  assign a7       = dp_a[8];

  always @(posedge clk) begin
    if (!rst) begin
      dp_a <= '0; dp_q <= '0; dp_m <= '0; dp_qm1 <= 1'b0; dp_cnt <= '0;
    end else begin
      if (c0) begin
        dp_m <= bus; dp_a <= '0; dp_qm1 <= 1'b0; dp_cnt <= '0;
      end
      if (c1) dp_q <= bus;
      if (c2) dp_a <= c3 ? dp_a - {dp_m[7], dp_m} : dp_a + {dp_m[7], dp_m};
      if (c4) begin
        if (op_o == OP_MUL) begin
          dp_a   <= {c6, dp_a[8:1]};
          dp_q   <= {dp_a[0], dp_q[7:1]};
          dp_qm1 <= dp_q[0];
        end else begin
          dp_a <= {dp_a[7:0], dp_q[7]};
          dp_q <= {dp_q[6:0], c6};
        end
      end
      if (c5) dp_cnt <= dp_cnt + 3'd1;
    end
  end

  function automatic logic [15:0] dp_z(input logic [1:0] op, input logic sub,
                                       input logic [7:0] a, input logic [7:0] q,
                                       input logic [7:0] m);
    logic [15:0] sx, sy;
    sx = {{8{m[7]}}, m};
    sy = {{8{q[7]}}, q};
    if (!op[1]) return sub ? sy - sx : sy + sx;
    return {a, q};
  endfunction

  // Reference model: expected output word per cycle, generated when an op is accepted.
  logic [12:0] exp_q[$];
  logic [1:0]  m_op = 2'b00;
  logic [15:0] m_z  = 16'h0;

  function automatic logic [12:0] mkw(input logic [1:0] op, input logic dn, input logic bs,
                                      input logic sel, input logic [7:0] c);
    return {op, dn, bs, sel, c};
  endfunction

  task automatic gen(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    int xs, ys, ix, iy, acc, r;
    logic b0, bm, qb;
    logic [7:0] cv;
    xs = $signed(x); ys = $signed(y); ix = int'(x); iy = int'(y);
    exp_q.push_back(mkw(op, 1'b0, 1'b1, 1'b0, 8'h01));
    exp_q.push_back(mkw(op, 1'b0, 1'b1, 1'b1, 8'h02));
    if (op == OP_MUL) begin
      acc = 0; bm = 1'b0;
      for (int i = 0; i < 8; i++) begin
        b0 = y[i]; cv = 8'h00;
        if (b0 && !bm) begin cv = 8'h0C; acc -= xs; end
        else if (!b0 && bm) begin cv = 8'h04; acc += xs; end
        exp_q.push_back(mkw(op, 1'b0, 1'b1, 1'b0, cv));
        exp_q.push_back(mkw(op, 1'b0, 1'b1, 1'b0, 8'h30 | ((acc < 0) ? 8'h40 : 8'h00)));
        acc = acc >>> 1;
        bm = b0;
      end
      m_z = 16'(xs * ys);
    end else if (op == OP_DIV) begin
      r = 0; qb = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        exp_q.push_back(mkw(op, 1'b0, 1'b1, 1'b0, 8'h10 | (qb ? 8'h40 : 8'h00)));
        r = 2 * r + int'(y[i]);
        exp_q.push_back(mkw(op, 1'b0, 1'b1, 1'b0, 8'h0C));
        r -= ix;
        exp_q.push_back(mkw(op, 1'b0, 1'b1, 1'b0, 8'h20));
        if (r < 0) begin
          exp_q.push_back(mkw(op, 1'b0, 1'b1, 1'b0, 8'h04));
          r += ix; qb = 1'b0;
        end else begin
          qb = 1'b1;
        end
      end
      exp_q.push_back(mkw(op, 1'b0, 1'b1, 1'b0, 8'h10 | (qb ? 8'h40 : 8'h00)));
      if (ix == 0) m_z = {y[6:0], 1'b0, 8'hFF};
      else         m_z = {8'((iy % ix) << 1), 8'(iy / ix)};
    end else begin
      m_z = op[0] ? 16'(ys - xs) : 16'(ys + xs);
    end
    exp_q.push_back(mkw(op, 1'b1, 1'b1, 1'b0, 8'h80 | (op[0] ? 8'h08 : 8'h00)));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        exp_q.delete();
        m_op = 2'b00;
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (start) begin
        m_op = op_in;
        gen(op_in, x_val, y_val);
      end
    end
  end

  // Compare process: every cycle after the first edge, plus the result whenever c7 is high.
  initial begin
    logic [12:0] exp_w;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_w = (exp_q.size() != 0) ? exp_q[0] : mkw(m_op, 1'b0, 1'b0, 1'b0, 8'h00);
      total++;
      if (w_act !== exp_w) begin
        bad++;
        $display("FAIL cycle_word t=%0t got=%h want=%h", $time, w_act, exp_w);
      end
      if (c7) begin
        last_z = dp_z(op_o, c3, dp_a[7:0], dp_q, dp_m);
        total++;
        if (last_z !== m_z) begin
          bad++;
          $display("FAIL result_z t=%0t got=%h want=%h", $time, last_z, m_z);
        end
      end
      if (done) n_done++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Starts one op from IDLE and follows it; optional stray start pulse or mid-op reset.
  task automatic run_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                        input int pulse_at, input int rst_at,
                        output int lat, output int nrest, output logic [15:0] z);
    bit fin;
    @(negedge clk); #1;
    op_in = op; x_val = x; y_val = y; start = 1'b1;
    lat = 0; nrest = 0; fin = 1'b0; z = '0;
    while (!fin) begin
      @(negedge clk); #1;
      lat++;
      if (op == OP_DIV && c2 && !c3) nrest++;
      if (rst_at != 0 && lat == rst_at) begin
        rst = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        chk("reset_mid_op", 32'(w_act), 32'h0);
        rst = 1'b1; fin = 1'b1;
      end else if (done) begin
        z = last_z; fin = 1'b1;
      end else if (lat >= 200) begin
        total++; bad++;
        $display("FAIL timeout: got no done want done op=%0d", op);
        fin = 1'b1;
      end else if (lat == pulse_at) begin
        start = 1'b1; op_in = 2'($urandom);
      end else begin
        start = 1'b0;
        if (lat == 1) op_in = 2'($urandom);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, nr, nd, pa;
    logic [15:0] z;
    logic [1:0] rop;
    logic [7:0] rx;
    bit fin;
    rst = 1'b0; start = 1'b0; op_in = 2'b00; x_val = '0; y_val = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_word", 32'(w_act), 32'h0);
    rst = 1'b1;

    run_op(OP_ADD, 8'd5, 8'd7, 0, 0, lat, nr, z);
    chk("add_lat", lat, 3);
    chk("add_z", 32'(z), 32'h000C);
    run_op(OP_SUB, 8'd5, 8'd3, 0, 0, lat, nr, z);
    chk("sub_z", 32'(z), 32'hFFFE);
    run_op(OP_MUL, 8'hFD, 8'd7, 0, 0, lat, nr, z);
    chk("mul_lat", lat, 19);
    chk("mul_z", 32'(z), 32'hFFEB);
    run_op(OP_MUL, 8'h80, 8'h80, 0, 0, lat, nr, z);
    chk("mul_min_z", 32'(z), 32'h4000);
    run_op(OP_DIV, 8'd7, 8'd100, 0, 0, lat, nr, z);
    chk("div_lat", lat, 33);
    chk("div_restores", nr, 5);
    chk("div_z", 32'(z), 32'h040E);
    run_op(OP_DIV, 8'd0, 8'h5A, 0, 0, lat, nr, z);
    chk("div0_lat", lat, 28);
    chk("div0_restores", nr, 0);
    chk("div0_quot", 32'(z[7:0]), 32'hFF);

    // Stray start during a multiply must be ignored.
    nd = n_done;
    run_op(OP_MUL, 8'hFD, 8'd7, 5, 0, lat, nr, z);
    repeat (3) @(negedge clk);
    #1;
    chk("busy_start_dones", n_done - nd, 1);
    chk("busy_start_lat", lat, 19);
    chk("busy_start_z", 32'(z), 32'hFFEB);

    // Reset in cycle 10 of a divide: no done, then a fresh add works.
    nd = n_done;
    run_op(OP_DIV, 8'd7, 8'd100, 0, 10, lat, nr, z);
    chk("reset_no_done", n_done - nd, 0);
    run_op(OP_ADD, 8'd5, 8'd7, 0, 0, lat, nr, z);
    chk("post_reset_add_z", 32'(z), 32'h000C);

    // Back-to-back with start held high; op relatched to SUB.
    @(negedge clk); #1;
    nd = n_done;
    op_in = OP_ADD; x_val = 8'd5; y_val = 8'd7; start = 1'b1;
    lat = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk); #1;
      lat++;
      if (lat == 1) op_in = OP_SUB;
      if (done) fin = 1'b1;
      else if (lat >= 100) begin
        total++; bad++; $display("FAIL b2b_first_timeout: got no done want done"); fin = 1'b1;
      end
    end
    chk("b2b_first_z", 32'(last_z), 32'h000C);
    lat = 0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk); #1;
      lat++;
      if (done) fin = 1'b1;
      else if (lat >= 100) begin
        total++; bad++; $display("FAIL b2b_second_timeout: got no done want done"); fin = 1'b1;
      end
    end
    start = 1'b0;
    chk("b2b_gap", lat, 4);
    chk("b2b_op", 32'(op_o), 32'(OP_SUB));
    chk("b2b_second_z", 32'(last_z), 32'h0002);
    repeat (4) @(negedge clk);
    #1;
    chk("b2b_dones", n_done - nd, 2);

    // Randomised operations; the compare process checks every cycle and result.
    for (int k = 0; k < 40; k++) begin
      rop = 2'($urandom);
      rx  = (rop == OP_DIV) ? 8'($urandom_range(0, 127)) : 8'($urandom);
      pa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 20)) : 0;
      run_op(rop, rx, 8'($urandom), pa, 0, lat, nr, z);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
